// File: rtl/crypt_out_if.sv
// Byte-output link between the FastModExp result stream, the UART transmitter
// and whoever supervises the crypto engine.
interface crypt_out_if;
  logic        mode;
  logic [5:0]  n_len;
  logic        fme_done;
  logic [31:0] fme_result;
  logic        flush;
  logic        ready_out;
  logic        start_out;
  logic [7:0]  data_out;
  logic        busy;
  logic        overrun;

  modport master (
    output mode, n_len, fme_done, fme_result, flush, ready_out,
    input  start_out, data_out, busy, overrun
  );

  modport slave (
    input  mode, n_len, fme_done, fme_result, flush, ready_out,
    output start_out, data_out, busy, overrun
  );
endinterface

// File: rtl/crypt_out.sv
// Serialises FastModExp blocks into UART bytes: whole 32-bit words when
// encrypting, a packed LSB-first bit stream of (n_len-1)-bit blocks when decrypting.
module crypt_out (
  input  logic       clk,
  input  logic       rst,
  crypt_out_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [39:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] enc_q, enc_d;
  logic [2:0]  enc_left_q, enc_left_d;
  logic        mode_q, mode_d;
  logic        fpend_q, fpend_d;
  logic        start_q, start_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  data_q, data_d;

  logic [5:0]  n_eff, nb;
  logic [31:0] mask;
  logic [39:0] ins;
  logic        avail;
  logic [7:0]  nxt_byte;

  // Payload width: n_len clamped to 32, minus the top bit; under 2 gives nothing.
  always_comb begin
    n_eff = (bus.n_len > 6'd32) ? 6'd32 : bus.n_len;
    nb    = (n_eff >= 6'd2) ? (n_eff - 6'd1) : 6'd0;
    for (int i = 0; i < 32; i++) mask[i] = (6'(i) < nb);
    ins   = {8'h00, bus.fme_result & mask} << cnt_q[2:0];
  end

  assign avail    = mode_q ? (enc_left_q != 3'd0) : (cnt_q >= 6'd8);
  assign nxt_byte = mode_q ? enc_q[7:0] : acc_q[7:0];

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    enc_d      = enc_q;
    enc_left_d = enc_left_q;
    mode_d     = mode_q;
    fpend_d    = fpend_q;
    start_d    = 1'b0;
    ovr_d      = ovr_q;
    data_d     = data_q;

    // Anything arriving while a block drains is either dropped or deferred.
    if (state_q != IDLE) begin
      if (bus.fme_done) ovr_d = 1'b1;
      if (bus.flush && !mode_q) fpend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.fme_done) begin
          state_d = SEND;
          mode_d  = bus.mode;
          if (bus.mode) begin
            enc_d      = bus.fme_result;
            enc_left_d = 3'd4;
          end else begin
            acc_d = acc_q | ins;
            cnt_d = cnt_q + nb;
            if (bus.flush) fpend_d = 1'b1;
          end
        end else if (bus.flush && !bus.mode) begin
          acc_d = '0;
          cnt_d = '0;
        end
      end
      SEND: begin
        if (avail) begin
          if (bus.ready_out) begin
            start_d = 1'b1;
            data_d  = nxt_byte;
            state_d = HOLD;
            if (mode_q) begin
              enc_d      = enc_q >> 8;
              enc_left_d = enc_left_q - 3'd1;
            end else begin
              acc_d = acc_q >> 8;
              cnt_d = cnt_q - 6'd8;
            end
          end
        end else begin
          state_d = IDLE;
          // Residue is encrypter padding: drop it once the block is out.
          if (fpend_q || (bus.flush && !mode_q)) begin
            acc_d = '0;
            cnt_d = '0;
          end
          fpend_d = 1'b0;
        end
      end
      HOLD:    state_d = SEND;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      enc_q      <= '0;
      enc_left_q <= '0;
      mode_q     <= 1'b0;
      fpend_q    <= 1'b0;
      start_q    <= 1'b0;
      ovr_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      enc_q      <= enc_d;
      enc_left_q <= enc_left_d;
      mode_q     <= mode_d;
      fpend_q    <= fpend_d;
      start_q    <= start_d;
      ovr_q      <= ovr_d;
      data_q     <= data_d;
    end
  end

  assign bus.start_out = start_q;
  assign bus.data_out  = data_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.overrun   = ovr_q;
endmodule

// File: tb/tb_crypt_out.sv
// Scoreboarded bench for crypt_out: expected bytes are queued as blocks are
// issued and popped by a negedge monitor on every start_out pulse.
module tb_crypt_out;
  logic clk = 1'b0;
  logic rst = 1'b0;
  crypt_out_if bus();

  crypt_out dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte monitor: ordering, pulse spacing and data_out stability.
  logic [7:0] last_data = 8'h00;
  int         last_cyc  = 0;
  bit         have_last = 0;
  always @(negedge clk) begin
    if (!rst) begin
      last_data = 8'h00;
      have_last = 0;
    end else if (bus.start_out) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_byte got=%02h expected=none", bus.data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_out !== e) begin
          n_err++;
          $display("FAIL byte_value got=%02h expected=%02h", bus.data_out, e);
        end
      end
      if (have_last) begin
        n_cmp++;
        if (cyc - last_cyc < 2) begin
          n_err++;
          $display("FAIL pulse_spacing got=%0d expected>=2", cyc - last_cyc);
        end
      end
      last_cyc  = cyc;
      have_last = 1;
      last_data = bus.data_out;
    end else begin
      n_cmp++;
      if (bus.data_out !== last_data) begin
        n_err++;
        $display("FAIL data_stable got=%02h expected=%02h", bus.data_out, last_data);
      end
    end
  end

  task automatic pulse_done(input logic m, input logic [5:0] nl, input logic [31:0] r,
                            input logic fl);
    @(posedge clk); #1;
    bus.mode = m; bus.n_len = nl; bus.fme_result = r; bus.fme_done = 1'b1; bus.flush = fl;
    @(posedge clk); #1;
    bus.fme_done = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic pulse_flush(input logic m);
    @(posedge clk); #1;
    bus.mode = m; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_idle_timeout busy=%b expected=0", tag, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.mode = 1'b0; bus.n_len = 6'd0; bus.fme_done = 1'b0; bus.fme_result = '0;
    bus.flush = 1'b0; bus.ready_out = 1'b1;
    #12;
    n_cmp++;
    if ({bus.start_out, bus.data_out, bus.busy, bus.overrun} !== 11'h0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b_%02h_%b_%b expected=0_00_0_0",
               bus.start_out, bus.data_out, bus.busy, bus.overrun);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_encrypt();
    exp_q.push_back(8'hD4); exp_q.push_back(8'hC3);
    exp_q.push_back(8'hB2); exp_q.push_back(8'hA1);
    pulse_done(1'b1, 6'd17, 32'hA1B2C3D4, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.start_out !== 1'b0 || bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL enc_latency start=%b busy=%b expected start=0 busy=1", bus.start_out, bus.busy);
    end
    wait_idle("enc");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL enc_drain left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_decrypt();
    // n_len=9: 8 payload bits, bit 8 ignored
    exp_q.push_back(8'hA5);
    pulse_done(1'b0, 6'd9, 32'h1A5, 1'b0); wait_idle("d9a");
    exp_q.push_back(8'h3C);
    pulse_done(1'b0, 6'd9, 32'h03C, 1'b0); wait_idle("d9b");
    // n_len=13: 12-bit blocks pack across bytes
    exp_q.push_back(8'hBC);
    pulse_done(1'b0, 6'd13, 32'hABC, 1'b0); wait_idle("d13a");
    exp_q.push_back(8'h3A); exp_q.push_back(8'h12);
    pulse_done(1'b0, 6'd13, 32'h123, 1'b0); wait_idle("d13b");
    // n_len=5: first block leaves 4 bits, no byte
    pulse_done(1'b0, 6'd5, 32'hA, 1'b0); wait_idle("d5a");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL dec_drain left=%0d expected=0", exp_q.size());
    end
    // flush in encrypt mode leaves residue alone
    pulse_flush(1'b1);
    exp_q.push_back(8'h5A);
    pulse_done(1'b0, 6'd5, 32'h5, 1'b0); wait_idle("d5b");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL dec5_drain left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    exp_q.push_back(8'hFF);
    pulse_done(1'b0, 6'd12, 32'h7FF, 1'b0); wait_idle("f1");
    pulse_flush(1'b0);
    exp_q.push_back(8'h01);
    pulse_done(1'b0, 6'd12, 32'h001, 1'b0); wait_idle("f2");
    pulse_flush(1'b0);
    // capture and flush together: residue dropped after the byte goes out
    exp_q.push_back(8'hFF);
    pulse_done(1'b0, 6'd12, 32'h7FF, 1'b1); wait_idle("f3");
    exp_q.push_back(8'hAB);
    pulse_done(1'b0, 6'd9, 32'h0AB, 1'b0); wait_idle("f4");
    // flush arriving mid-block is deferred
    exp_q.push_back(8'hFF);
    pulse_done(1'b0, 6'd12, 32'h7FF, 1'b0);
    bus.flush = 1'b1; @(posedge clk); #1 bus.flush = 1'b0;
    wait_idle("f5");
    exp_q.push_back(8'hCD);
    pulse_done(1'b0, 6'd9, 32'h0CD, 1'b0); wait_idle("f6");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL flush_drain left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_nlen_bounds();
    // n_len above 32 behaves as 32: 31 payload bits
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    pulse_done(1'b0, 6'd40, 32'hFFFF_FFFF, 1'b0); wait_idle("n40");
    pulse_done(1'b0, 6'd1, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL n1_busy got=%b expected=1", bus.busy);
    end
    wait_idle("n1");
    pulse_done(1'b0, 6'd0, 32'hFFFF_FFFF, 1'b0); wait_idle("n0");
    // 7 residue bits + 1 new bit complete one byte
    exp_q.push_back(8'hFF);
    pulse_done(1'b0, 6'd2, 32'h3, 1'b0); wait_idle("n2");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL nlen_drain left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    bus.ready_out = 1'b0;
    exp_q.push_back(8'h44); exp_q.push_back(8'h33);
    exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    pulse_done(1'b1, 6'd32, 32'h11223344, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.start_out !== 1'b0) begin
        n_err++;
        $display("FAIL stall_start cycle=%0d got=%b expected=0", i, bus.start_out);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_busy got=%b expected=1", bus.busy);
    end
    @(posedge clk); #1 bus.ready_out = 1'b1;
    wait_idle("stall");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_drain left=%0d expected=0", exp_q.size());
    end
  endtask

  task automatic test_overrun();
    n_cmp++;
    if (bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_pre got=%b expected=0", bus.overrun);
    end
    exp_q.push_back(8'h88); exp_q.push_back(8'h77);
    exp_q.push_back(8'h66); exp_q.push_back(8'h55);
    pulse_done(1'b1, 6'd32, 32'h55667788, 1'b0);
    @(posedge clk);
    pulse_done(1'b1, 6'd32, 32'hDEADBEEF, 1'b0);
    wait_idle("ovr");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.overrun !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL ovr_sticky got=%b left=%0d expected=1 left=0", bus.overrun, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    exp_q.push_back(8'hBE); exp_q.push_back(8'hBA);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hCA);
    pulse_done(1'b1, 6'd32, 32'hCAFEBABE, 1'b0);
    while (exp_q.size() == 4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (exp_q.size() != 3) begin
      n_err++;
      $display("FAIL rstmid_first_byte left=%0d expected=3", exp_q.size());
    end
    @(posedge clk); #3 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.start_out, bus.data_out, bus.busy, bus.overrun} !== 11'h0) begin
      n_err++;
      $display("FAIL rstmid_outputs got=%b_%02h_%b_%b expected=0_00_0_0",
               bus.start_out, bus.data_out, bus.busy, bus.overrun);
    end
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b1;
    exp_q.push_back(8'hEE);
    pulse_done(1'b0, 6'd9, 32'h1EE, 1'b0); wait_idle("rstmid");
    n_cmp++;
    if (exp_q.size() != 0 || bus.overrun !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_after left=%0d ovr=%b expected left=0 ovr=0", exp_q.size(), bus.overrun);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_flush();
    test_nlen_bounds();
    test_stall();
    test_overrun();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
